// File: rtl/paralelo_serial_pkg.sv
// Shared symbols and state encoding for the serial link (transmitter and receiver).
// Bit order is selected elsewhere by PS_LSB_FIRST_EN; nothing here depends on it.
package paralelo_serial_pkg;

    localparam int unsigned PS_WORD_BITS = 8;

    localparam logic [PS_WORD_BITS-1:0] COM_SYM  = 8'hBC;
    localparam logic [PS_WORD_BITS-1:0] IDLE_SYM = 8'h7C;

    typedef enum logic {
        ST_SYNC   = 1'b0,
        ST_ACTIVE = 1'b1
    } ps_state_t;

    // Word placed in the shift register at a word boundary.
    function automatic logic [PS_WORD_BITS-1:0] ps_select_word(
        input ps_state_t                 state,
        input logic                      valid,
        input logic [PS_WORD_BITS-1:0]   data
    );
        logic [PS_WORD_BITS-1:0] word;
        word = COM_SYM;
        if (state == ST_ACTIVE) begin
            word = valid ? data : IDLE_SYM;
        end
        return word;
    endfunction

endpackage

// File: rtl/paralelo_serial_bit_cnt.sv
// 3-bit word-phase counter: resets to 7 so the first edge after reset is a word
// boundary; wrap flags the boundary cycle (count == 7).
module ps_bit_cnt (
    input  logic clk32f,
    input  logic reset,
    output logic wrap
);

    logic [2:0] bit_cnt_reg;

    always_ff @(posedge clk32f) begin
        if (reset) begin
            bit_cnt_reg <= 3'd7;
        end else begin
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
        end
    end

    assign wrap = (bit_cnt_reg == 3'd7);

endmodule

// File: rtl/paralelo_serial.sv
// Parallel-to-serial transmitter: SYNC_WORDS COM symbols after reset, then user bytes
// or IDLE, one word per 8 clk32f cycles. Define PS_LSB_FIRST_EN for LSB-first order.
module paralelo_serial
    import paralelo_serial_pkg::*;
#(
    parameter int unsigned SYNC_WORDS = 4
) (
    input  logic       clk32f,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       load,
    output logic       data_out,
    output logic       active
);

    localparam logic [3:0] SYNC_LAST = 4'(SYNC_WORDS - 1);

    ps_state_t  state_reg, state_next;
    logic [3:0] sync_cnt_reg, sync_cnt_next;
    logic [7:0] shreg_reg, shreg_next;
    logic [7:0] shift_word;
    logic       wrap;

    ps_bit_cnt u_bit_cnt (
        .clk32f (clk32f),
        .reset  (reset),
        .wrap   (wrap)
    );

    // Shift network: the vacated end fills with zero so a truncated word never leaks.
    genvar gi;
`ifdef PS_LSB_FIRST_EN
    localparam int unsigned OUT_BIT = 0;
    for (gi = 0; gi < 7; gi++) begin : g_shift_right
        assign shift_word[gi] = shreg_reg[gi+1];
    end
    assign shift_word[7] = 1'b0;
`else
    localparam int unsigned OUT_BIT = 7;
    for (gi = 1; gi < 8; gi++) begin : g_shift_left
        assign shift_word[gi] = shreg_reg[gi-1];
    end
    assign shift_word[0] = 1'b0;
`endif

    always_ff @(posedge clk32f) begin
        if (reset) begin
            state_reg    <= ST_SYNC;
            sync_cnt_reg <= 4'd0;
            shreg_reg    <= 8'h00;
        end else begin
            state_reg    <= state_next;
            sync_cnt_reg <= sync_cnt_next;
            shreg_reg    <= shreg_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        sync_cnt_next = sync_cnt_reg;
        shreg_next    = shift_word;
        if (wrap) begin
            shreg_next = ps_select_word(state_reg, valid_in, data_in);
            if (state_reg == ST_SYNC) begin
                sync_cnt_next = sync_cnt_reg + 4'd1;
                // Leaving SYNC on the edge that loads the last COM.
                if (sync_cnt_reg == SYNC_LAST) begin
                    state_next = ST_ACTIVE;
                end
            end
        end
    end

    assign active   = (state_reg == ST_ACTIVE);
    assign load     = active & wrap;
    assign data_out = shreg_reg[OUT_BIT];

endmodule
